instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: walks a small instruction memory, resolves
// jumps and halts locally, and hands every other instruction downstream
// through a valid/ready handshake.
module instr_fetch #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned JUMP_LIMIT = 32
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              run,
    output logic [ADDR_W-1:0] address,
    input  logic [7:0]        instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_opcode,
    output logic [2:0]        out_ra,
    output logic [2:0]        out_rb,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted,
    output logic              loop_err,
    output logic [7:0]        issue_count
);

    localparam int unsigned JCNT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc;
    logic [7:0]          ir;
    logic [JCNT_W-1:0]   jcnt;

    logic                is_ctrl;
    logic                is_halt;
    logic                is_jump;
    logic                jump_last;
    logic                accept;

    // Decode of the word currently presented by the memory
    always_comb begin
        is_ctrl   = (instruction[7:6] == 2'b11);
        is_halt   = is_ctrl && instruction[5];
        is_jump   = is_ctrl && !instruction[5];
        jump_last = is_jump && (jcnt == JCNT_W'(JUMP_LIMIT - 1));
        accept    = (state == ISSUE) && out_ready;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (run) state_nxt = FETCH;
            FETCH: begin
                if (is_halt || jump_last) state_nxt = HALT;
                else if (!is_jump)        state_nxt = ISSUE;
            end
            ISSUE: if (out_ready) state_nxt = FETCH;
            HALT:  state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; clear overrides every transition
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_nxt;
    end

    // Datapath: PC, instruction register, jump-run counter, status flags
    always_ff @(posedge clk) begin
        if (clear) begin
            pc          <= '0;
            ir          <= '0;
            out_pc      <= '0;
            jcnt        <= '0;
            out_valid   <= 1'b0;
            halted      <= 1'b0;
            loop_err    <= 1'b0;
            issue_count <= '0;
        end else begin
            out_valid <= (state_nxt == ISSUE);
            halted    <= (state_nxt == HALT);
            if (state == FETCH) begin
                if (is_jump) begin
                    pc   <= ADDR_W'(instruction[4:0]);
                    jcnt <= jcnt + JCNT_W'(1);
                    if (jump_last) loop_err <= 1'b1;
                end else if (!is_halt) begin
                    ir     <= instruction;
                    out_pc <= pc;
                    pc     <= pc + ADDR_W'(1);
                end
            end
            if (accept) begin
                jcnt <= '0;
                if (issue_count != 8'hFF) issue_count <= issue_count + 8'd1;
            end
        end
    end

    // Memory address tracks the PC; issued fields slice the IR
    always_comb begin
        address    = pc;
        out_opcode = ir[7:6];
        out_ra     = ir[5:3];
        out_rb     = ir[2:0];
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scenario table plus hand-written corner sequences,
// with an ISA-level reference model feeding an in-order scoreboard.
module tb_instr_fetch;

    localparam int unsigned AW = 5;

    logic          clk;
    logic          clear;
    logic          run;
    logic [AW-1:0] address;
    logic [7:0]    instruction;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_opcode;
    logic [2:0]    out_ra;
    logic [2:0]    out_rb;
    logic [AW-1:0] out_pc;
    logic          halted;
    logic          loop_err;
    logic [7:0]    issue_count;

    logic [7:0] mem [32];

    instr_fetch #(.ADDR_W(AW), .JUMP_LIMIT(32)) dut (
        .clk        (clk),
        .clear      (clear),
        .run        (run),
        .address    (address),
        .instruction(instruction),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_ra     (out_ra),
        .out_rb     (out_rb),
        .out_pc     (out_pc),
        .halted     (halted),
        .loop_err   (loop_err),
        .issue_count(issue_count)
    );

    assign instruction = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [7:0]    ir;
    } exp_t;

    typedef struct {
        logic [0:4][7:0] p;
        logic [7:0]      fill;
        logic [7:0]      w31;
        int              exp_n;
        bit              exp_h;
        bit              exp_le;
        logic [AW-1:0]   exp_a;
    } vec_t;

    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   popped  = 0;
    bit   sb_en   = 0;
    bit   seen_valid = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        sb_en = 0;
        clear = 1'b1;
        run   = 1'b0;
        tick();
        clear = 1'b0;
        seen_valid = 0;
        popped = 0;
        exp_q.delete();
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 32; i++) mem[i] = v.fill;
        for (int i = 0; i < 5; i++)  mem[i] = v.p[i];
        mem[31] = v.w31;
    endtask

    // Architectural model: issue order with every instruction accepted
    task automatic build_exp(input int max_n, output bit h, output bit le,
                             output int n, output logic [AW-1:0] a);
        logic [AW-1:0] pc;
        logic [7:0]    w;
        int            jc;
        pc = '0; jc = 0; n = 0; h = 0; le = 0;
        for (int step = 0; step < 5000 && !h && n < max_n; step++) begin
            w = mem[pc];
            if (w[7:6] == 2'b11) begin
                if (w[5]) h = 1;
                else begin
                    jc++;
                    pc = AW'(w[4:0]);
                    if (jc == 32) begin h = 1; le = 1; end
                end
            end else begin
                exp_q.push_back('{pc, w});
                n++;
                pc = pc + AW'(1);
                jc = 0;
            end
        end
        a = pc;
    endtask

    // Scoreboard: compare every accepted instruction against the model
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) seen_valid = 1;
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_extra: got pc %0d expected no issue", out_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", 32'(out_pc), 32'(e.pc));
                check("sb_ir", 32'({out_opcode, out_ra, out_rb}), 32'(e.ir));
                popped++;
            end
        end
    end

    initial begin
        vec_t          vecs [6];
        vec_t          v;
        bit            mh, ml;
        int            mn;
        logic [AW-1:0] ma;
        int            cyc;
        int            times [$];

        vecs[0] = '{{8'h44, 8'h49, 8'h18, 8'h89, 8'hE0}, 8'h00, 8'h00, 4,  1'b1, 1'b0, 5'd4};
        vecs[1] = '{{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 0,  1'b1, 1'b1, 5'd0};
        vecs[2] = '{{8'hE0, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 0,  1'b1, 1'b0, 5'd0};
        vecs[3] = '{{8'h44, 8'hC3, 8'h00, 8'hE0, 8'h00}, 8'h00, 8'h00, 1,  1'b1, 1'b0, 5'd3};
        vecs[4] = '{{8'h44, 8'hC1, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 1,  1'b1, 1'b1, 5'd1};
        vecs[5] = '{{8'h12, 8'h12, 8'h12, 8'h12, 8'h12}, 8'h12, 8'hE0, 31, 1'b1, 1'b0, 5'd31};

        clear = 1'b1; run = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        tick();
        tick();

        // Reset state
        check("rst_valid",  32'(out_valid), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_lerr",   32'(loop_err), 0);
        check("rst_count",  32'(issue_count), 0);
        check("rst_addr",   32'(address), 0);
        check("rst_outpc",  32'(out_pc), 0);
        check("rst_fields", 32'({out_opcode, out_ra, out_rb}), 0);
        clear = 1'b0;
        tick(); tick(); tick();
        check("idle_addr",  32'(address), 0);
        check("idle_valid", 32'(out_valid), 0);

        // Table: programs that end in HALT
        for (int t = 0; t < 6; t++) begin
            v = vecs[t];
            do_clear();
            load(v);
            build_exp(1000, mh, ml, mn, ma);
            out_ready = 1'b1;
            sb_en = 1;
            pulse_run();
            for (int c = 0; c < 3000 && !halted; c++) tick();
            check($sformatf("t%0d_halted", t), 32'(halted), 32'(v.exp_h));
            check($sformatf("t%0d_lerr", t),   32'(loop_err), 32'(v.exp_le));
            check($sformatf("t%0d_count", t),  32'(issue_count), 32'(v.exp_n));
            check($sformatf("t%0d_addr", t),   32'(address), 32'(v.exp_a));
            check($sformatf("t%0d_popped", t), 32'(popped), 32'(v.exp_n));
            check($sformatf("t%0d_qleft", t),  32'(exp_q.size()), 0);
            check($sformatf("t%0d_seenv", t),  32'(seen_valid), 32'(v.exp_n != 0));
            // HALT ignores run and out_ready
            for (int c = 0; c < 10; c++) begin
                run = 1'b1;
                out_ready = c[0];
                tick();
            end
            run = 1'b0;
            check($sformatf("t%0d_haddr", t),  32'(address), 32'(v.exp_a));
            check($sformatf("t%0d_hhalt", t),  32'(halted), 1);
            check($sformatf("t%0d_hvalid", t), 32'(out_valid), 0);
            check($sformatf("t%0d_hcount", t), 32'(issue_count), 32'(v.exp_n));
        end

        // Basic program with jump back to 3: order, latency, pc3 period
        v = '{{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3}, 8'h00, 8'h00, 0, 1'b0, 1'b0, 5'd0};
        do_clear();
        load(v);
        build_exp(12, mh, ml, mn, ma);
        out_ready = 1'b1;
        sb_en = 1;
        pulse_run();
        check("lat_fetch_valid", 32'(out_valid), 0);
        check("lat_fetch_addr",  32'(address), 0);
        tick();
        check("lat_issue_valid", 32'(out_valid), 1);
        check("lat_issue_pc",    32'(out_pc), 0);
        cyc = 1;
        times.delete();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            tick();
            cyc++;
            if (out_valid && out_ready && out_pc == 5'd3) times.push_back(cyc);
        end
        sb_en = 0;
        check("loop_pc3_count", 32'(times.size()), 9);
        if (times.size() >= 3) begin
            check("loop_pc3_gap_first", 32'(times[1] - times[0]), 3);
            check("loop_pc3_gap_last",  32'(times[times.size()-1] - times[times.size()-2]), 3);
        end

        // Back-pressure on the first issue
        do_clear();
        load(v);
        build_exp(1, mh, ml, mn, ma);
        out_ready = 1'b0;
        sb_en = 1;
        pulse_run();
        tick();
        for (int c = 0; c < 5; c++) begin
            check("stall_valid",  32'(out_valid), 1);
            check("stall_pc",     32'(out_pc), 0);
            check("stall_fields", 32'({out_opcode, out_ra, out_rb}), 32'h44);
            check("stall_count",  32'(issue_count), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        sb_en = 0;
        check("stall_accept_count", 32'(issue_count), 1);
        check("stall_accept_valid", 32'(out_valid), 0);
        check("stall_popped",       32'(popped), 1);

        // All-zero memory: PC wrap and issue_count saturation
        v = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, 8'h00, 0, 1'b0, 1'b0, 5'd0};
        do_clear();
        load(v);
        build_exp(300, mh, ml, mn, ma);
        out_ready = 1'b1;
        sb_en = 1;
        pulse_run();
        for (int c = 0; c < 1500 && exp_q.size() != 0; c++) tick();
        sb_en = 0;
        check("sat_popped", 32'(popped), 300);
        check("sat_count",  32'(issue_count), 255);

        // Clear in the middle of an accepted handshake
        v = '{{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3}, 8'h00, 8'h00, 0, 1'b0, 1'b0, 5'd0};
        do_clear();
        load(v);
        out_ready = 1'b1;
        pulse_run();
        tick(); tick(); tick();
        check("mid_valid_before", 32'(out_valid), 1);
        check("mid_count_before", 32'(issue_count), 1);
        clear = 1'b1;
        run   = 1'b1;
        tick();
        clear = 1'b0;
        run   = 1'b0;
        check("mid_valid",  32'(out_valid), 0);
        check("mid_halted", 32'(halted), 0);
        check("mid_lerr",   32'(loop_err), 0);
        check("mid_count",  32'(issue_count), 0);
        check("mid_addr",   32'(address), 0);
        check("mid_outpc",  32'(out_pc), 0);
        check("mid_fields", 32'({out_opcode, out_ra, out_rb}), 0);
        tick();
        check("mid_idle_addr",  32'(address), 0);
        check("mid_idle_valid", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
